// File: rtl/matmul_mac_sequencer_if.sv
// Operand/result buffer ports, MAC hookup and start/busy/done handshake of the
// matrix-multiply sequencer. The master side is the sequencer.
interface matmul_mac_sequencer_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(N*N)
);
  logic              start, busy, done;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] a_rdata, b_rdata, mac_a, mac_b, mac_accum, c_wdata;
  logic              mac_clear, mac_enable, c_we;

  modport master (
    input  start, a_rdata, b_rdata, mac_accum,
    output busy, done, a_addr, b_addr, mac_clear, mac_enable, mac_a, mac_b,
           c_addr, c_wdata, c_we
  );

  modport slave (
    output start, a_rdata, b_rdata, mac_accum,
    input  busy, done, a_addr, b_addr, mac_clear, mac_enable, mac_a, mac_b,
           c_addr, c_wdata, c_we
  );
endinterface

// File: rtl/matmul_mac_sequencer.sv
// Sequences one MAC over C = A x B: per element clear, N operand feeds, write-back.
// Buffers are synchronous-read, so addresses lead the MAC enable by one cycle.
module matmul_mac_sequencer #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(N*N)
) (
  input  logic                   clk,
  input  logic                   reset,
  matmul_mac_sequencer_if.master bus
);
  localparam int CW = $clog2(N+1);
  localparam logic [ADDR_W-1:0] NA = ADDR_W'(N);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     i, j, k, i_n, j_n, k_n;
  logic              busy, done, clr, en, we;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] mac_a, mac_b, c_wdata;

  function automatic logic [ADDR_W-1:0] ext(input logic [CW-1:0] v);
    return ADDR_W'(v);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    clr     = 1'b0;
    en      = 1'b0;
    we      = 1'b0;
    done    = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    c_addr  = '0;
    busy    = (state != IDLE);
    case (state)
      IDLE: if (bus.start) begin
        state_n = CLEAR;
        i_n     = '0;
        j_n     = '0;
        k_n     = '0;
      end
      CLEAR: begin
        clr     = 1'b1;
        a_addr  = ext(i) * NA;
        b_addr  = ext(j);
        k_n     = CW'(1);
        state_n = FEED;
      end
      // Enable consumes the pair addressed last cycle; the k==N cycle only drains.
      FEED: begin
        en = 1'b1;
        if (k < CW'(N)) begin
          a_addr = ext(i) * NA + ext(k);
          b_addr = ext(k) * NA + ext(j);
          k_n    = k + CW'(1);
        end else begin
          k_n     = '0;
          state_n = WRITE;
        end
      end
      WRITE: begin
        we     = 1'b1;
        c_addr = ext(i) * NA + ext(j);
        if (j < CW'(N-1)) begin
          j_n     = j + CW'(1);
          state_n = CLEAR;
        end else if (i < CW'(N-1)) begin
          j_n     = '0;
          i_n     = i + CW'(1);
          state_n = CLEAR;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        i_n     = '0;
        j_n     = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mac_a   = bus.a_rdata;
  assign mac_b   = bus.b_rdata;
  assign c_wdata = bus.mac_accum;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.a_addr     = a_addr;
  assign bus.b_addr     = b_addr;
  assign bus.c_addr     = c_addr;
  assign bus.mac_clear  = clr;
  assign bus.mac_enable = en;
  assign bus.c_we       = we;
  assign bus.mac_a      = mac_a;
  assign bus.mac_b      = mac_b;
  assign bus.c_wdata    = c_wdata;
endmodule
